// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the program/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int MAX_BURST_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_M0 = 2'd1,
        LOCK_M1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    function automatic master_t other_master(input master_t m);
        return (m == M0) ? M1 : M0;
    endfunction

    function automatic arb_state_t lock_state_of(input master_t m);
        return (m == M0) ? LOCK_M0 : LOCK_M1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the arbiter bundled as one port.
// slave = arbiter view; master = requesters plus memory as seen from outside.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  m0_req;
    logic                  m0_we;
    logic                  m0_lock;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;

    logic                  m1_req;
    logic                  m1_we;
    logic                  m1_lock;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;

    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_en;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  mem_dout,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
        output mem_en, mem_rd_en, mem_wr_en, mem_addr, mem_din
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output mem_dout,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
        input  mem_en, mem_rd_en, mem_wr_en, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin selector: on a tie the input not picked last wins.
// Purely combinational, no backpressure of its own.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  master_t last,
    output master_t sel,
    output logic    valid
);

    always_comb begin
        valid = req0 | req1;
        sel   = M0;
        if (req0 && req1) begin
            sel = other_master(last);
        end else if (req1) begin
            sel = M1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port sync memory: grant and command are combinational
// (same cycle), read responses come back one cycle later; a loser simply holds its request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
)(
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    master_t          last_q, last_d;
    logic             m0_rvalid_q, m0_rvalid_d;
    logic             m1_rvalid_q, m1_rvalid_d;

    master_t rr_sel;
    logic    rr_vld;

    logic            locked;
    master_t         owner;
    logic            owner_req, owner_lock, other_req, cap_hit;
    logic            gnt_vld;
    master_t         gnt_sel;
    logic            gnt_we, gnt_lock;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;

    rr_pick2 u_rr_pick2 (
        .req0  (bus.m0_req),
        .req1  (bus.m1_req),
        .last  (last_q),
        .sel   (rr_sel),
        .valid (rr_vld)
    );

    // The lock owner wins unless it has used up its burst while the other side waits.
    always_comb begin
        locked     = (state_q != IDLE);
        owner      = (state_q == LOCK_M1) ? M1 : M0;
        owner_req  = (owner == M0) ? bus.m0_req  : bus.m1_req;
        owner_lock = (owner == M0) ? bus.m0_lock : bus.m1_lock;
        other_req  = (owner == M0) ? bus.m1_req  : bus.m0_req;
        cap_hit    = locked && owner_req && other_req && (burst_cnt_q == CNT_LAST);

        gnt_vld = rr_vld && rst;
        gnt_sel = rr_sel;
        if (locked && owner_req) begin
            gnt_sel = cap_hit ? other_master(owner) : owner;
        end
    end

    always_comb begin
        gnt_we    = 1'b0;
        gnt_lock  = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        if (gnt_vld) begin
            if (gnt_sel == M0) begin
                gnt_we    = bus.m0_we;
                gnt_lock  = bus.m0_lock;
                gnt_addr  = bus.m0_addr;
                gnt_wdata = bus.m0_wdata;
            end else begin
                gnt_we    = bus.m1_we;
                gnt_lock  = bus.m1_lock;
                gnt_addr  = bus.m1_addr;
                gnt_wdata = bus.m1_wdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = gnt_vld ? gnt_sel : last_q;
        m0_rvalid_d = gnt_vld && (gnt_sel == M0) && !gnt_we;
        m1_rvalid_d = gnt_vld && (gnt_sel == M1) && !gnt_we;

        unique case (state_q)
            IDLE: begin
                if (gnt_vld && gnt_lock) begin
                    state_d = lock_state_of(gnt_sel);
                end
            end
            default: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (cap_hit) begin
                    state_d = gnt_lock ? lock_state_of(gnt_sel) : IDLE;
                end else if (!owner_lock) begin
                    state_d = IDLE;
                end
            end
        endcase

        // Counter wraps when nobody contends, so the owner keeps streaming without a gap.
        if (state_d != state_q) begin
            burst_cnt_d = '0;
        end else if (locked && gnt_vld && (gnt_sel == owner)) begin
            burst_cnt_d = (burst_cnt_q == CNT_LAST) ? '0 : burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_q      <= M1;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    assign bus.m0_gnt    = gnt_vld && (gnt_sel == M0);
    assign bus.m1_gnt    = gnt_vld && (gnt_sel == M1);
    // A response still in flight when reset asserts is never shown.
    assign bus.m0_rvalid = m0_rvalid_q && rst;
    assign bus.m1_rvalid = m1_rvalid_q && rst;
    assign bus.rdata     = bus.mem_dout;
    assign bus.mem_en    = gnt_vld;
    assign bus.mem_rd_en = gnt_vld && !gnt_we;
    assign bus.mem_wr_en = gnt_vld && gnt_we;
    assign bus.mem_addr  = gnt_addr;
    assign bus.mem_din   = gnt_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a per-cycle reference model and literal checks.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MAX_BURST = 8;

    typedef struct packed {
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    typedef struct {
        int            g;      // 0 none, 1 M0, 2 M1, 3 both
        logic          rden;
        logic [AW-1:0] addr;
        logic          rv0;
        logic          rv1;
        logic [DW-1:0] rdata;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rst_leak = 0;

    op_t  q0[$];
    op_t  q1[$];
    cyc_t lg[$];
    bit   pop0 = 0;
    bit   pop1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int i);
        if (i == 'h010) return 16'hBEEF;
        return DW'(i * 257) ^ 16'h5A5A;
    endfunction

    function automatic op_t rd(input int a, input bit lk);
        op_t o;
        o.we = 1'b0; o.lock = lk; o.addr = AW'(a); o.wdata = DW'(a ^ 'h0F0F);
        return o;
    endfunction

    function automatic op_t wr(input int a, input int d, input bit lk);
        op_t o;
        o.we = 1'b1; o.lock = lk; o.addr = AW'(a); o.wdata = DW'(d);
        return o;
    endfunction

    // Synchronous memory, one-cycle read latency.
    logic [DW-1:0] mem [4096];
    bit mem_init = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pattern(i);
            bus.mem_dout <= '0;
            mem_init <= 1;
        end else begin
            if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_din;
            if (bus.mem_rd_en) bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    // Requester drivers: present the queue head until it is granted.
    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        forever begin
            @(posedge clk); #2;
            if (pop0 && q0.size() > 0) void'(q0.pop_front());
            if (pop1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                bus.m0_req = 1; bus.m0_we = q0[0].we; bus.m0_lock = q0[0].lock;
                bus.m0_addr = q0[0].addr; bus.m0_wdata = q0[0].wdata;
            end else begin
                bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
            end
            if (q1.size() > 0) begin
                bus.m1_req = 1; bus.m1_we = q1[0].we; bus.m1_lock = q1[0].lock;
                bus.m1_addr = q1[0].addr; bus.m1_wdata = q1[0].wdata;
            end else begin
                bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
            end
        end
    end

    // Reference model: lock owner (-1 none), consecutive owner grants, last winner.
    int            m_owner = -1;
    int            m_run   = 0;
    int            m_last  = 1;
    bit            pend0   = 0;
    bit            pend1   = 0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] ref_mem [4096];
    bit            ref_init = 0;

    always @(negedge clk) begin
        int eg;
        bit r0, r1, l0, l1, w0, w1, ew, el;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        cyc_t c;
        if (!ref_init) begin
            for (int i = 0; i < 4096; i++) ref_mem[i] = pattern(i);
            ref_init = 1;
        end
        r0 = bus.m0_req; r1 = bus.m1_req; l0 = bus.m0_lock; l1 = bus.m1_lock;
        w0 = bus.m0_we;  w1 = bus.m1_we;

        // A waiting contender may preempt after every MAX_BURST-th owner grant.
        eg = -1;
        if (rst) begin
            if (m_owner >= 0 && (m_owner == 0 ? r0 : r1)) begin
                if ((m_owner == 0 ? r1 : r0) && (m_run % MAX_BURST == 0)) eg = 1 - m_owner;
                else eg = m_owner;
            end else if (r0 && r1) eg = (m_last == 0) ? 1 : 0;
            else if (r0) eg = 0;
            else if (r1) eg = 1;
        end
        ea = (eg == 0) ? bus.m0_addr  : (eg == 1) ? bus.m1_addr  : '0;
        ed = (eg == 0) ? bus.m0_wdata : (eg == 1) ? bus.m1_wdata : '0;
        ew = (eg == 0) ? w0 : (eg == 1) ? w1 : 1'b0;
        el = (eg == 0) ? l0 : (eg == 1) ? l1 : 1'b0;

        chk("m0_gnt",    bus.m0_gnt,    eg == 0);
        chk("m1_gnt",    bus.m1_gnt,    eg == 1);
        chk("mem_en",    bus.mem_en,    eg >= 0);
        chk("mem_rd_en", bus.mem_rd_en, eg >= 0 && !ew);
        chk("mem_wr_en", bus.mem_wr_en, eg >= 0 && ew);
        chk("mem_addr",  bus.mem_addr,  ea);
        chk("mem_din",   bus.mem_din,   ed);
        chk("m0_rvalid", bus.m0_rvalid, rst && pend0);
        chk("m1_rvalid", bus.m1_rvalid, rst && pend1);
        if (rst && (pend0 || pend1)) chk("rdata", bus.rdata, pend_data);
        if (!rst && (bus.m0_gnt || bus.m1_gnt || bus.mem_en)) rst_leak++;

        c.g = (bus.m0_gnt ? 1 : 0) + (bus.m1_gnt ? 2 : 0);
        c.rden = bus.mem_rd_en; c.addr = bus.mem_addr;
        c.rv0 = bus.m0_rvalid; c.rv1 = bus.m1_rvalid; c.rdata = bus.rdata;
        lg.push_back(c);
        pop0 = bus.m0_gnt;
        pop1 = bus.m1_gnt;

        if (!rst) begin
            m_owner = -1; m_run = 0; m_last = 1; pend0 = 0; pend1 = 0;
        end else begin
            pend0 = (eg == 0) && !ew;
            pend1 = (eg == 1) && !ew;
            if (eg >= 0 && !ew) pend_data = ref_mem[ea];
            if (eg >= 0 && ew) ref_mem[ea] = ed;
            if (eg >= 0) m_last = eg;
            if (m_owner >= 0) begin
                if (!(m_owner == 0 ? r0 : r1)) m_owner = -1;
                else if (eg == m_owner) begin
                    if (el) m_run++;
                    else m_owner = -1;
                end else if (el) begin
                    m_owner = eg; m_run = 1;
                end else m_owner = -1;
            end else if (eg >= 0 && el) begin
                m_owner = eg; m_run = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 300, 1);
        repeat (3) tick();
    endtask

    initial begin
        // Reset hold with both masters requesting.
        rst = 0;
        q0.push_back(rd('h010, 0));
        q1.push_back(rd('h011, 0));
        repeat (6) @(posedge clk);
        #1;
        chk("reset_grants", rst_leak, 0);
        chk("reset_m0_req_seen", bus.m0_req, 1);
        rst = 1;
        lg.delete();
        wait_idle();
        chk("first_after_reset", lg[0].g, 1);
        chk("second_after_reset", lg[1].g, 2);

        // Single read of preloaded word.
        lg.delete();
        q0.push_back(rd('h010, 0));
        wait_idle();
        chk("single_gnt", lg[0].g, 1);
        chk("single_rden", lg[0].rden, 1);
        chk("single_addr", lg[0].addr, 'h010);
        chk("single_rv0", lg[1].rv0, 1);
        chk("single_rdata", lg[1].rdata, 'hBEEF);
        chk("single_rv1", lg[1].rv1, 0);

        // Alternation plus write-then-read across masters.
        lg.delete();
        q0.push_back(rd('h030, 0)); q0.push_back(rd('h020, 0)); q0.push_back(rd('h031, 0));
        q1.push_back(wr('h020, 'h1234, 0)); q1.push_back(wr('h021, 'h5678, 0));
        q1.push_back(rd('h021, 0));
        wait_idle();
        for (int i = 0; i < 6; i++) chk("alt_gnt", lg[i].g, (i % 2 == 0) ? 2 : 1);
        chk("raw_rv0", lg[4].rv0, 1);
        chk("raw_rdata", lg[4].rdata, 'h1234);
        chk("raw2_rv1", lg[5].rv1, 1);
        chk("raw2_rdata", lg[5].rdata, 'h5678);

        // Burst cap: locked M1 stream, M0 contends from cycle 2.
        lg.delete();
        for (int i = 0; i < 20; i++) q1.push_back(wr('h100 + i, 'hC000 + i, 1));
        tick(); tick();
        q0.push_back(rd('h010, 0));
        wait_idle();
        for (int i = 0; i < 8; i++) chk("burst_m1_first", lg[i].g, 2);
        chk("burst_m0_slot", lg[8].g, 1);
        chk("burst_m0_rdata", lg[9].rdata, 'hBEEF);
        for (int i = 9; i < 21; i++) chk("burst_m1_rest", lg[i].g, 2);
        chk("burst_done", lg[21].g, 0);

        // Lock without contention: no gap at the counter wrap.
        lg.delete();
        for (int i = 0; i < 20; i++) q0.push_back(rd('h200 + i, 1));
        wait_idle();
        for (int i = 0; i < 20; i++) begin
            chk("lock_m0_gnt", lg[i].g, 1);
            chk("lock_m0_rdata", lg[i + 1].rdata, pattern('h200 + i));
        end
        chk("lock_done", lg[20].g, 0);

        // Reset right after a granted locked read.
        lg.delete();
        q0.push_back(rd('h010, 1));
        tick();
        rst = 0;
        tick();
        rst = 1;
        q0.push_back(rd('h013, 0));
        q1.push_back(rd('h011, 0)); q1.push_back(rd('h012, 0));
        wait_idle();
        chk("mid_gnt", lg[0].g, 1);
        chk("mid_rv0_in_reset", lg[1].rv0, 0);
        chk("mid_rv0_after", lg[2].rv0, 0);
        chk("mid_tie_m0", lg[2].g, 1);
        chk("mid_then_m1", lg[3].g, 2);
        chk("mid_then_m1b", lg[4].g, 2);
        chk("mid_rdata", lg[3].rdata, pattern('h013));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port 16-bit synchronous program/data memory between two requesters.
- M0 is the CPU.
- M1 is the program loader / debug port, which replaces the bench-side back-door file load.
- Sits between requesters and memory: one access per cycle, round-robin arbitration, optional bounded burst lock, read-response routing for the memory's 1-cycle read latency.

Parameters:
ADDR_WIDTH, 12, word address width (4096 x 16-bit words)
DATA_WIDTH, 16, memory data width
MAX_BURST, 8, max consecutive grants to a locking owner while the other master requests

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset; synchronous, active-low (0 = reset)
m0_req  input  1  M0 access request; addr/we/wdata held stable until granted
m0_we  input  1  M0 write (1) / read (0)
m0_lock  input  1  M0 requests to keep ownership for following cycles
m0_addr  input  ADDR_WIDTH  M0 word address
m0_wdata  input  DATA_WIDTH  M0 write data
m0_gnt  output  1  M0 access issued this cycle
m0_rvalid  output  1  rdata holds M0 read result
m1_req, m1_we, m1_lock, m1_addr, m1_wdata  inputs  as M0  M1 equivalents
m1_gnt, m1_rvalid  outputs  1  M1 equivalents
rdata  output  DATA_WIDTH  read data, direct from mem_dout, shared by both masters
mem_en  output  1  memory enable, = m0_gnt | m1_gnt
mem_rd_en  output  1  read strobe
mem_wr_en  output  1  write strobe
mem_addr  output  ADDR_WIDTH  address of granted master
mem_din  output  DATA_WIDTH  write data of granted master
mem_dout  input  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd_en

Behaviour:
- Grant path:
  - gnt outputs and all mem_* outputs are combinational from the current request inputs plus registered state.
  - The command reaches memory in the same cycle as gnt.
  - At most one gnt per cycle.
  - No gnt without the matching req.
- Grant decision order:
  - (a) Locked owner wins if its req is high.
  - (b) Otherwise, a single requester wins.
  - (c) Otherwise, on a tie, the master not granted last wins (round-robin pointer `last`).
- mem_rd_en = gnt & ~we; mem_wr_en = gnt & we; mem_addr and mem_din are muxed by the granted master, 0 when idle.
- Read response:
  - rvalid_mX is registered: it goes high exactly 1 cycle after a granted read by mX.
  - rdata = mem_dout in that cycle.
  - Writes never raise rvalid.
- FSM states: IDLE, LOCK_M0, LOCK_M1.
  - IDLE -> LOCK_Mx when Mx is granted with mx_lock=1.
  - LOCK_Mx -> IDLE when mx_lock=0 at a cycle with mx_req=1, or when mx_req=0.
  - LOCK_Mx -> LOCK_My (other master) when burst_cnt reaches MAX_BURST-1 while my_req=1. My is granted that cycle; lock is taken only if my_lock=1, else the state goes to IDLE.
- burst_cnt:
  - Width $clog2(MAX_BURST).
  - Increments per grant to the locked owner.
  - Clears on any state change.
  - If the other master is idle at MAX_BURST-1, the owner keeps the lock and the count wraps to 0.
- `last` updates on every grant.
- Reset (rst=0 at a clock edge):
  - state=IDLE, burst_cnt=0, last=M1 (so M0 wins the first tie), both rvalid=0.
  - gnt and mem_* outputs are forced 0 while rst=0.
- Reset mid-operation: a read granted in the cycle before reset produces no rvalid after reset; a lock is dropped.
- A read and a write never issue in the same cycle. Read-after-write to the same address from different masters returns the new data (memory write-first is not required; accesses are serialized across cycles).

Decomposition:
- Package mem_arb_pkg:
  - typedef enum {IDLE, LOCK_M0, LOCK_M1} arb_state_t
  - typedef enum {M0, M1} master_t
  - localparam default widths
- One sub-module, rr_pick2: two-input round-robin selector (req0, req1, last -> sel, valid), purely combinational, reused by the bus bridge later.
- The FSM, burst counter and response tracking stay in the top module.

Test Plan:
- Reset hold: rst=0 for 6 cycles with both reqs high -> no gnt, mem_en=0, rvalid=0; first cycle after release -> m0_gnt=1.
- Single read: M0 read addr 0x010, memory preloaded 0xBEEF -> mem_rd_en=1 with mem_addr=0x010 in cycle t; m0_rvalid=1 and rdata=0xBEEF at t+1; m1_rvalid stays 0.
- Alternation: both request continuously without lock -> gnt alternates M0,M1,M0,M1; M1 write 0x1234 to 0x020, then M0 read 0x020 -> 0x1234.
- Burst cap: M1 lock=1 with 20 continuous writes, M0 requesting from cycle 2 -> M1 gets exactly 8 consecutive grants, then M0 is granted for 1 cycle, then M1 resumes.
- Lock without contention: M0 lock=1 for 20 reads, M1 idle -> 20 consecutive M0 grants, no gap at the wrap.
- Reset mid-read: M0 read granted at t, rst=0 at t+1 -> m0_rvalid stays 0, state IDLE, M0 wins the first tie after reset.
